// File: rtl/binary_term_stream_encoder_pkg.sv
// Shared types and helpers for term-quantization blocks (binary operand <-> power-of-two term streams).
package binary_term_stream_encoder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  function automatic int exp_width(input int data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

endpackage

// File: rtl/binary_term_stream_encoder_pe.sv
// Combinational priority encoder: index of the highest set bit of a residue, plus a nonzero flag.
module term_priority_encoder
  import binary_term_stream_encoder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int EXP_WIDTH  = exp_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] residue,
  output logic [EXP_WIDTH-1:0]  exp,
  output logic                  any
);

  always_comb begin
    exp = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (residue[i]) exp = EXP_WIDTH'(i);
    end
    any = |residue;
  end

endmodule

// File: rtl/binary_term_stream_encoder.sv
// Serialises signed operands into MSB-first +/-2^k term beats, truncated to MAX_TERMS per operand.
module binary_term_stream_encoder
  import binary_term_stream_encoder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_TERMS  = 3,
  parameter int EXP_WIDTH  = exp_width(DATA_WIDTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [EXP_WIDTH-1:0]         out_exp,
  output logic                         out_sign,
  output logic                         out_zero,
  output logic                         out_last,
  output logic                         out_trunc
);

  localparam int CNT_W = (MAX_TERMS > 1) ? $clog2(MAX_TERMS + 1) : 1;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   residue_q, residue_d;
  logic                    sign_q, sign_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic [EXP_WIDTH-1:0]    enc_exp;
  logic                    enc_any;
  logic [DATA_WIDTH-1:0]   cleared;
  logic [DATA_WIDTH-1:0]   magnitude;
  logic                    emit, zero_c, last_c, beat, accept;

  term_priority_encoder #(
    .DATA_WIDTH (DATA_WIDTH),
    .EXP_WIDTH  (EXP_WIDTH)
  ) u_pe (
    .residue (residue_q),
    .exp     (enc_exp),
    .any     (enc_any)
  );

  always_comb begin
    emit    = (state_q == ST_EMIT);
    cleared = residue_q & ~(DATA_WIDTH'(1) << enc_exp);
    zero_c  = emit && !enc_any && (count_q == '0);
    last_c  = emit && (zero_c || (cleared == '0) || (count_q == CNT_W'(MAX_TERMS - 1)));

    out_valid = emit;
    out_exp   = emit ? enc_exp : '0;
    out_sign  = emit && sign_q;
    out_zero  = zero_c;
    out_last  = last_c;
    out_trunc = last_c && !zero_c && (cleared != '0);

    beat     = emit && out_ready;
    in_ready = !emit || (out_ready && last_c);
    accept   = in_valid && in_ready;

    // The most negative operand negates to itself, which reads as 2^(DATA_WIDTH-1) unsigned.
    magnitude = in_data[DATA_WIDTH-1] ? $unsigned(-in_data) : $unsigned(in_data);

    state_d   = state_q;
    residue_d = residue_q;
    sign_d    = sign_q;
    count_d   = count_q;

    if (beat) begin
      residue_d = cleared;
      count_d   = count_q + CNT_W'(1);
      if (last_c) state_d = ST_IDLE;
    end

    if (accept) begin
      residue_d = magnitude;
      sign_d    = in_data[DATA_WIDTH-1];
      count_d   = '0;
      state_d   = ST_EMIT;
    end
  end

  // Control state is reset; operand data is qualified by state and needs none.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
    residue_q <= residue_d;
    sign_q    <= sign_d;
  end

endmodule
